xdata_bridge: RTL and testbench



---
 rtl/xdata_bridge_pkg.sv | 27 ++
 rtl/xdata_bridge.sv | 120 ++++++++++++
 tb/tb_xdata_bridge.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/xdata_bridge_pkg.sv
// xdata_bridge_pkg: shared constants for the controller data-port bridge.
// Holds the 3-bit FSM state encodings, the address split point between the
// decoder-select bits and the peripheral offset, and the address-map bases.
// Latency: n/a (constants only). Backpressure: n/a.
package xdata_bridge_pkg;

    localparam int XB_ADDR_W     = 12;
    localparam int XB_SEL_ADDR_W = 2;
    localparam int XB_DATA_W     = 32;

    // Bit position where the decoder-select field starts; everything below is
    // the offset handed to the peripherals.
    localparam int XB_SEL_LSB    = XB_ADDR_W - XB_SEL_ADDR_W;

    // Segment bases of the data address map, shared with the decoder.
    localparam logic [XB_ADDR_W-1:0] XB_BASE_SEG0 = 12'h000;
    localparam logic [XB_ADDR_W-1:0] XB_BASE_SEG1 = 12'h400;
    localparam logic [XB_ADDR_W-1:0] XB_BASE_SEG2 = 12'h800;
    localparam logic [XB_ADDR_W-1:0] XB_BASE_SEG3 = 12'hC00;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_RDWAIT  = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_TRAPPED = 3'd4;

endpackage

// File: rtl/xdata_bridge.sv
// xdata_bridge: registers one controller data request, presents the select
// bits + dec_sel to the decoder and offset/we/wdata to the peripherals,
// captures read data one cycle after ISSUE and returns a one-cycle response.
// Latency: accept at T -> write rsp at T+2, read rsp at T+3.
// Backpressure: req_ready only in IDLE; response has none (single strobe).
// A decoder trap during ISSUE latches halted until rst.
// Ports: clk/rst (sync, active-high); req_* controller request; rsp_* response;
// dec_* decoder side; per_* peripheral side; halted trap status.
// Optional macro XDATA_BRIDGE_TRAP_INFO_EN adds trap_addr/trap_wdata outputs
// that capture the trapping request and hold it until rst.
module xdata_bridge
    import xdata_bridge_pkg::*;
#(
    parameter int ADDR_W     = XB_ADDR_W,
    parameter int SEL_ADDR_W = XB_SEL_ADDR_W,
    parameter int DATA_W     = XB_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic                         req_we,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic [SEL_ADDR_W-1:0]        dec_addr,
    output logic                         dec_sel,
    input  logic [DATA_W-1:0]            dec_data_to_rd,
    input  logic                         dec_trap,
    output logic [ADDR_W-SEL_ADDR_W-1:0] per_addr,
    output logic                         per_we,
    output logic [DATA_W-1:0]            per_wdata,
    output logic                         halted
`ifdef XDATA_BRIDGE_TRAP_INFO_EN
    ,
    output logic [ADDR_W-1:0]            trap_addr,
    output logic [DATA_W-1:0]            trap_wdata
`endif
);

    localparam int PER_W = ADDR_W - SEL_ADDR_W;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_accept;

    assign w_accept = (r_state == ST_IDLE) && req_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (req_valid) w_next_state = ST_ISSUE;
            // Trap wins over both the write and the response.
            ST_ISSUE:   w_next_state = dec_trap ? ST_TRAPPED :
                                       (r_we ? ST_RESP : ST_RDWAIT);
            ST_RDWAIT:  w_next_state = ST_RESP;
            ST_RESP:    w_next_state = ST_IDLE;
            ST_TRAPPED: w_next_state = ST_TRAPPED;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_wdata <= req_wdata;
                // Cleared here so a write response returns zero data.
                r_rdata <= '0;
            end
            // Decoder behaves like synchronous memory: data is valid by the
            // end of the cycle following ISSUE.
            if (r_state == ST_RDWAIT) begin
                r_rdata <= dec_data_to_rd;
            end
        end
    end

`ifdef XDATA_BRIDGE_TRAP_INFO_EN
    logic [ADDR_W-1:0] r_trap_addr;
    logic [DATA_W-1:0] r_trap_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap_addr  <= '0;
            r_trap_wdata <= '0;
        end else if ((r_state == ST_ISSUE) && dec_trap) begin
            r_trap_addr  <= r_addr;
            r_trap_wdata <= r_wdata;
        end
    end

    assign trap_addr  = r_trap_addr;
    assign trap_wdata = r_trap_wdata;
`endif

    assign req_ready = (r_state == ST_IDLE);
    assign dec_sel   = (r_state == ST_ISSUE) || (r_state == ST_RDWAIT);
    assign per_we    = (r_state == ST_ISSUE) && r_we && !dec_trap;
    assign rsp_valid = (r_state == ST_RESP);
    assign halted    = (r_state == ST_TRAPPED);
    assign rsp_rdata = r_rdata;
    assign dec_addr  = r_addr[ADDR_W-1 -: SEL_ADDR_W];
    assign per_addr  = r_addr[PER_W-1:0];
    assign per_wdata = r_wdata;

endmodule

// File: tb/tb_xdata_bridge.sv
// tb_xdata_bridge: drives directed and random requests through xdata_bridge and
// compares every cycle against expectations derived from the address split
// and the per-transaction latency table.
module tb_xdata_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        dec_trap = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] dec_data_to_rd = '0;
    logic        req_ready, rsp_valid, dec_sel, per_we, halted;
    logic [31:0] rsp_rdata, per_wdata;
    logic [1:0]  dec_addr;
    logic [9:0]  per_addr;
`ifdef XDATA_BRIDGE_TRAP_INFO_EN
    logic [11:0] trap_addr;
    logic [31:0] trap_wdata;
`endif

    int n_checks = 0;
    int n_errors = 0;

    xdata_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .dec_addr(dec_addr), .dec_sel(dec_sel),
        .dec_data_to_rd(dec_data_to_rd), .dec_trap(dec_trap),
        .per_addr(per_addr), .per_we(per_we), .per_wdata(per_wdata),
        .halted(halted)
`ifdef XDATA_BRIDGE_TRAP_INFO_EN
        , .trap_addr(trap_addr), .trap_wdata(trap_wdata)
`endif
    );

    always #5 clk = ~clk;

    // Control outputs packed as {req_ready, dec_sel, per_we, rsp_valid, halted}.
    wire [4:0] w_ctl = {req_ready, dec_sel, per_we, rsp_valid, halted};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        dec_trap = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_ctl", w_ctl, 5'b10000);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_dec_addr", dec_addr, 0);
        chk("rst_per_addr", per_addr, 0);
        chk("rst_per_wdata", per_wdata, 0);
`ifdef XDATA_BRIDGE_TRAP_INFO_EN
        chk("rst_trap_addr", trap_addr, 0);
        chk("rst_trap_wdata", trap_wdata, 0);
`endif
    endtask

    // One complete transaction starting from IDLE; ends in IDLE.
    task automatic run_txn(input logic [11:0] a, input logic we, input logic [31:0] wd,
                           input logic [31:0] rd, input logic trap);
        logic [1:0] exp_dec;
        logic [9:0] exp_per;
        exp_dec = 2'(a / 1024);
        exp_per = 10'(a % 1024);
        // T: offer
        req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
        dec_trap = 1'b0; dec_data_to_rd = $urandom;
        #1 chk("offer_ctl", w_ctl, 5'b10000);
        tick();
        // T+1: ISSUE; scramble request inputs to prove they were registered
        req_valid = 1'b0; req_addr = 12'($urandom); req_wdata = $urandom;
        dec_trap = trap; dec_data_to_rd = $urandom;
        #1;
        chk("issue_ctl", w_ctl, {1'b0, 1'b1, we & ~trap, 1'b0, 1'b0});
        chk("issue_dec_addr", dec_addr, exp_dec);
        chk("issue_per_addr", per_addr, exp_per);
        chk("issue_per_wdata", per_wdata, wd);
        tick();
        dec_trap = 1'b0;
        if (trap) begin
            #1 chk("trap_ctl", w_ctl, 5'b00001);
            req_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("trap_hold_ctl", w_ctl, 5'b00001);
            end
`ifdef XDATA_BRIDGE_TRAP_INFO_EN
            chk("trap_addr", trap_addr, a);
            chk("trap_wdata", trap_wdata, wd);
`endif
            do_reset();
        end else if (we) begin
            #1 chk("wr_resp_ctl", w_ctl, 5'b00010);
            chk("wr_rdata", rsp_rdata, 0);
            tick();
            chk("wr_next_ctl", w_ctl, 5'b10000);
        end else begin
            dec_data_to_rd = rd;
            #1 chk("rdwait_ctl", w_ctl, 5'b01000);
            chk("rdwait_dec_addr", dec_addr, exp_dec);
            chk("rdwait_per_addr", per_addr, exp_per);
            tick();
            dec_data_to_rd = $urandom;
            #1 chk("rd_resp_ctl", w_ctl, 5'b00010);
            chk("rd_rdata", rsp_rdata, rd);
            tick();
            chk("rd_next_ctl", w_ctl, 5'b10000);
        end
    endtask

    initial begin
        do_reset();

        run_txn(12'h005, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        run_txn(12'h412, 1'b1, 32'h12345678, 32'h0, 1'b0);
        run_txn(12'h9F0, 1'b0, 32'h0, 32'h0, 1'b0);           // unmapped read -> 0
        run_txn(12'hC00, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b1);    // trap on write
        run_txn(12'h3FF, 1'b0, 32'h0, 32'h13579BDF, 1'b1);    // trap on read

        for (int i = 0; i < 40; i++) begin
            run_txn(12'($urandom), 1'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 15) == 0));
        end

        // Back-to-back reads with req_valid held: accept every 4 cycles.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'($urandom); dec_trap = 1'b0;
        for (int c = 0; c < 9; c++) begin
            #1;
            case (c % 4)
                0:       chk("b2b_ctl", w_ctl, 5'b10000);
                3:       chk("b2b_ctl", w_ctl, 5'b00010);
                default: chk("b2b_ctl", w_ctl, 5'b01000);
            endcase
            if (c == 8) req_valid = 1'b0;
            tick();
        end
        chk("b2b_idle_ctl", w_ctl, 5'b10000);

        // Reset while in RDWAIT: request dropped, no response.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'hFFF; req_wdata = 32'hFFFFFFFF;
        tick();
        req_valid = 1'b0;
        tick();
        dec_data_to_rd = 32'hFFFFFFFF;
        #1 chk("pre_rst_rdwait_ctl", w_ctl, 5'b01000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rdwait_rst_ctl", w_ctl, 5'b10000);
        chk("rdwait_rst_rdata", rsp_rdata, 0);
        chk("rdwait_rst_dec_addr", dec_addr, 0);
        chk("rdwait_rst_per_addr", per_addr, 0);
        chk("rdwait_rst_per_wdata", per_wdata, 0);
        tick();
        chk("rdwait_rst_after_ctl", w_ctl, 5'b10000);

        run_txn(12'h805, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
